// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: sequences the CLK_EN input of one CLK_Gate cell (wake, ack, idle-off).
// Optional macro CG_TEST_MODE_EN adds i_test_mode, which forces o_clk_en high for DFT clocking.
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_busy,
`ifdef CG_TEST_MODE_EN
  input  logic               i_test_mode,
`endif
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_clk_en,
  output logic               o_gated
);

  typedef enum logic [1:0] {
    S_OFF  = 2'b00,
    S_WAKE = 2'b01,
    S_ON   = 2'b10,
    S_IDLE = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD = CNT_WIDTH'(WAKE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_clk_en;
  logic                 r_gated;
  logic [NUM_REQ-1:0]   r_ack;
  logic                 w_any_req;

  assign w_any_req = |i_req;

  // The shared counter times both the wake delay and the idle timeout; it only decrements when nonzero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_OFF;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_gated  <= 1'b1;
      r_ack    <= '0;
    end else begin
      case (r_state)
        S_OFF: begin
          r_ack <= '0;
          if (w_any_req) begin
            r_state  <= S_WAKE;
            r_clk_en <= 1'b1;
            r_gated  <= 1'b0;
            r_cnt    <= WAKE_LOAD;
          end
        end
        S_WAKE: begin
          if (r_cnt == '0) begin
            r_state <= S_ON;
            r_ack   <= i_req;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_ON: begin
          if (!w_any_req && !i_busy) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_cnt   <= IDLE_LOAD;
          end else begin
            r_ack <= i_req;
          end
        end
        S_IDLE: begin
          // A new request or busy wins over a timeout landing on the same edge.
          if (w_any_req || i_busy) begin
            r_state <= S_ON;
            r_ack   <= i_req;
          end else if (r_cnt == '0) begin
            r_state  <= S_OFF;
            r_clk_en <= 1'b0;
            r_gated  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state  <= S_OFF;
          r_clk_en <= 1'b0;
          r_gated  <= 1'b1;
          r_ack    <= '0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign o_ack   = r_ack;
  assign o_gated = r_gated;

`ifdef CG_TEST_MODE_EN
  assign o_clk_en = i_test_mode | r_clk_en;
`else
  assign o_clk_en = r_clk_en;
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (WAKE_CYCLES=2, IDLE_CYCLES=16): vector table plus multi-cycle sequences.
// Build with +define+CG_TEST_MODE_EN to also exercise the test-mode override.
module tb_clk_gate_ctrl;

  logic       clk;
  logic       rstN;
  logic [3:0] req;
  logic       busy;
  logic [3:0] ack;
  logic       clkEn;
  logic       gated;
`ifdef CG_TEST_MODE_EN
  logic       testMode;
`endif

  int vectors;
  int miscompares;

  logic enLat;
  logic gatedClk;
  int   gatedEdges;

  typedef struct {
    logic [3:0] req;
    logic       busy;
    logic [3:0] expAck;
    logic       expEn;
    logic       expGated;
  } vec_t;

  vec_t table_q[14];

  clk_gate_ctrl #(
    .NUM_REQ    (4),
    .WAKE_CYCLES(2),
    .IDLE_CYCLES(16),
    .CNT_WIDTH  (8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_req      (req),
    .i_busy     (busy),
`ifdef CG_TEST_MODE_EN
    .i_test_mode(testMode),
`endif
    .o_ack      (ack),
    .o_clk_en   (clkEn),
    .o_gated    (gated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural latch-based clock gate, so the bench can watch the gated clock stop.
  initial enLat = 1'b0;
  always @(clk or clkEn) if (!clk) enLat = clkEn;
  assign gatedClk = clk & enLat;

  initial gatedEdges = 0;
  always @(posedge gatedClk) gatedEdges = gatedEdges + 1;

  task automatic applyStimulus(input logic [3:0] r, input logic b);
    req  = r;
    busy = b;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expAck,
                             input logic expEn, input logic expGated);
    vectors++;
    if (ack !== expAck || clkEn !== expEn || gated !== expGated) begin
      miscompares++;
      $display("[TB] FAIL %s: ack=%b clk_en=%b gated=%b, expected ack=%b clk_en=%b gated=%b",
               name, ack, clkEn, gated, expAck, expEn, expGated);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Quiet cycles in IDLE during which the clock must stay enabled.
  task automatic idleCountdown(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(4'b0000, 1'b0);
      checkOutput(name, 4'b0000, 1'b1, 1'b0);
    end
  endtask

  task automatic wakeFromOff(input logic [3:0] r);
    applyStimulus(r, 1'b0);
    checkOutput("wake_en", 4'b0000, 1'b1, 1'b0);
    applyStimulus(r, 1'b0);
    checkOutput("wake_wait", 4'b0000, 1'b1, 1'b0);
    applyStimulus(r, 1'b0);
    checkOutput("wake_ack", r, 1'b1, 1'b0);
  endtask

  initial begin
    int startEdges;
    vectors     = 0;
    miscompares = 0;
    rstN        = 1'b0;
    req         = '0;
    busy        = 1'b0;
`ifdef CG_TEST_MODE_EN
    testMode    = 1'b0;
`endif

    table_q[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
    table_q[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1};
    table_q[2]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    table_q[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    table_q[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    table_q[5]  = '{4'b0011, 1'b0, 4'b0011, 1'b1, 1'b0};
    table_q[6]  = '{4'b1010, 1'b0, 4'b1010, 1'b1, 1'b0};
    table_q[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    table_q[8]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
    table_q[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    table_q[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0};
    table_q[11] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};
    table_q[12] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0};
    table_q[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0};

    #12;
    checkOutput("reset_state", 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(table_q[i].req, table_q[i].busy);
      checkOutput($sformatf("vec[%0d]", i), table_q[i].expAck, table_q[i].expEn, table_q[i].expGated);
    end

    // Last vector dropped REQ in ON at edge t; clock must fall exactly after t+16.
    idleCountdown("idle_hold", 15);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("idle_gate_off", 4'b0000, 1'b0, 1'b1);
    startEdges = gatedEdges;
    repeat (8) applyStimulus(4'b0000, 1'b0);
    checkCount("gated_clk_stopped", gatedEdges - startEdges, 0);
    checkOutput("off_stays", 4'b0000, 1'b0, 1'b1);

    // A request that disappears during WAKE still completes the wake.
    applyStimulus(4'b1000, 1'b0);
    checkOutput("wdrop_wake", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("wdrop_wait", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("wdrop_on", 4'b0000, 1'b1, 1'b0);

    // Into IDLE (CNT=15), count down to CNT=5, then re-request.
    applyStimulus(4'b0000, 1'b0);
    checkOutput("rewake_idle", 4'b0000, 1'b1, 1'b0);
    idleCountdown("rewake_hold", 10);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("rewake_ack", 4'b0100, 1'b1, 1'b0);

    startEdges = gatedEdges;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(4'b0000, 1'b1);
      checkOutput("busy_hold", 4'b0000, 1'b1, 1'b0);
    end
    checkCount("gated_clk_running", gatedEdges - startEdges, 40);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("busy_fall", 4'b0000, 1'b1, 1'b0);
    idleCountdown("busy_idle", 15);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("busy_gate_off", 4'b0000, 1'b0, 1'b1);

    // Request arriving on the same edge the idle timeout expires keeps the clock on.
    wakeFromOff(4'b0001);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("race_idle", 4'b0000, 1'b1, 1'b0);
    idleCountdown("race_hold", 15);
    applyStimulus(4'b0010, 1'b0);
    checkOutput("race_req_wins", 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0110, 1'b0);
    checkOutput("new_req_in_on", 4'b0110, 1'b1, 1'b0);

    // Asynchronous reset in the middle of ON.
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 1'b0, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("post_reset_off", 4'b0000, 1'b0, 1'b1);

`ifdef CG_TEST_MODE_EN
    testMode = 1'b1;
    #1;
    checkOutput("test_mode_on", 4'b0000, 1'b1, 1'b1);
    testMode = 1'b0;
    #1;
    checkOutput("test_mode_off", 4'b0000, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
